// File: rtl/stage2_pkg.sv
// Shared pipeline definitions: word width, opcode map, condition codes, NOP encoding.
package stage2_pkg;

  localparam int unsigned WORD = 16;
  localparam int unsigned OPW  = 5;
  localparam int unsigned REGW = 4;

  localparam logic [OPW-1:0] OPADD  = 5'd0;
  localparam logic [OPW-1:0] OPSUB  = 5'd1;
  localparam logic [OPW-1:0] OPAND  = 5'd2;
  localparam logic [OPW-1:0] OPBIC  = 5'd3;
  localparam logic [OPW-1:0] OPEOR  = 5'd4;
  localparam logic [OPW-1:0] OPORR  = 5'd5;
  localparam logic [OPW-1:0] OPMOV  = 5'd6;
  localparam logic [OPW-1:0] OPNEG  = 5'd7;
  localparam logic [OPW-1:0] OPMUL  = 5'd8;
  localparam logic [OPW-1:0] OPSHA  = 5'd9;
  localparam logic [OPW-1:0] OPSLT  = 5'd10;
  localparam logic [OPW-1:0] OPLDR  = 5'd11;
  localparam logic [OPW-1:0] OPSTR  = 5'd12;
  localparam logic [OPW-1:0] OPSYS  = 5'd13;
  localparam logic [OPW-1:0] OPADDF = 5'd14;
  localparam logic [OPW-1:0] OPSUBF = 5'd15;
  localparam logic [OPW-1:0] OPMULF = 5'd16;
  localparam logic [OPW-1:0] OPFTOI = 5'd17;
  localparam logic [OPW-1:0] OPITOF = 5'd18;
  localparam logic [OPW-1:0] OPRECF = 5'd19;
  localparam logic [OPW-1:0] OPNOP  = 5'd20;
  localparam logic [OPW-1:0] OPPRE  = 5'd24;  // any opcode with [4:3]=11

  localparam logic [1:0] CC_AL = 2'b00;
  localparam logic [1:0] CC_S  = 2'b01;
  localparam logic [1:0] CC_NE = 2'b10;
  localparam logic [1:0] CC_EQ = 2'b11;

  localparam logic [WORD-1:0] NOP_INSN = 16'hA000;

  // Instruction field view of a 16-bit instruction word.
  typedef struct packed {
    logic [OPW-1:0]  opcode;
    logic [1:0]      cc;
    logic            imm;
    logic [REGW-1:0] dest;
    logic [REGW-1:0] op2;
  } insn_t;

endpackage

// File: rtl/stage2_alu.sv
// Stage2 combinational datapath: ALU result plus instruction class decode.
module stage2_alu
  import stage2_pkg::*;
(
  input  logic [OPW-1:0]  opcode,
  input  logic [WORD-1:0] a,
  input  logic [WORD-1:0] b,
  output logic [WORD-1:0] result,
  output logic            writes,
  output logic            is_mem,
  output logic            is_bad
);

  logic [2*WORD-1:0] w_prod;
  logic [WORD-1:0]   w_mag;
  logic [WORD-1:0]   w_sha;

  assign w_prod = (2*WORD)'(a) * (2*WORD)'(b);
  assign w_mag  = b[WORD-1] ? (WORD'(0) - b) : b;

  // Signed shift amount: positive shifts left, negative arithmetic-right, saturating at 16.
  always_comb begin
    w_sha = a;
    if (b != '0) begin
      if (!b[WORD-1]) begin
        w_sha = (w_mag >= WORD'(WORD)) ? '0 : (a << w_mag[3:0]);
      end else begin
        w_sha = (w_mag >= WORD'(WORD)) ? {WORD{a[WORD-1]}}
                                       : WORD'($signed(a) >>> w_mag[3:0]);
      end
    end
  end

  always_comb begin
    result = '0;
    writes = 1'b0;
    is_mem = 1'b0;
    is_bad = 1'b0;
    case (opcode)
      OPADD:   begin result = a + b;             writes = 1'b1; end
      OPSUB:   begin result = a - b;             writes = 1'b1; end
      OPAND:   begin result = a & b;             writes = 1'b1; end
      OPBIC:   begin result = a & ~b;            writes = 1'b1; end
      OPEOR:   begin result = a ^ b;             writes = 1'b1; end
      OPORR:   begin result = a | b;             writes = 1'b1; end
      OPMOV:   begin result = b;                 writes = 1'b1; end
      OPNEG:   begin result = WORD'(0) - b;      writes = 1'b1; end
      OPMUL:   begin result = w_prod[WORD-1:0];  writes = 1'b1; end
      OPSHA:   begin result = w_sha;             writes = 1'b1; end
      OPSLT:   begin
        result = WORD'($signed(a) < $signed(b));
        writes = 1'b1;
      end
      OPLDR, OPSTR: is_mem = 1'b1;
      OPADDF, OPSUBF, OPMULF, OPFTOI, OPITOF, OPRECF,
      5'd21, 5'd22, 5'd23: is_bad = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/stage2.sv
// Execute stage: registers the ALU result, memory request, Z flag and sticky status bits.
module stage2
  import stage2_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [WORD-1:0]  ir_in,
  input  logic [WORD-1:0]  pc_in,
  input  logic [WORD-1:0]  rd_val_in,
  input  logic [WORD-1:0]  op2_in,
  output logic [WORD-1:0]  ir_out,
  output logic [WORD-1:0]  pc_out,
  output logic [WORD-1:0]  result_out,
  output logic [REGW-1:0]  dest_out,
  output logic             wr_en_out,
  output logic             mem_rd_out,
  output logic             mem_wr_out,
  output logic [WORD-1:0]  mem_addr_out,
  output logic [WORD-1:0]  mem_data_out,
  output logic             z_out,
  output logic             halt_out,
  output logic             badop_out
);

  insn_t           w_insn;
  logic [WORD-1:0] w_result;
  logic            w_writes;
  logic            w_is_mem;
  logic            w_is_bad;

  logic [WORD-1:0] r_ir, r_pc, r_result, r_maddr, r_mdata;
  logic [REGW-1:0] r_dest;
  logic            r_wr, r_mrd, r_mwr, r_z, r_halt, r_badop;

  assign w_insn = insn_t'(ir_in);

  stage2_alu u_alu (
    .opcode (w_insn.opcode),
    .a      (rd_val_in),
    .b      (op2_in),
    .result (w_result),
    .writes (w_writes),
    .is_mem (w_is_mem),
    .is_bad (w_is_bad)
  );

  // Stall freezes everything; strobes are rewritten on every consumed instruction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ir     <= NOP_INSN;
      r_pc     <= '0;
      r_result <= '0;
      r_dest   <= '0;
      r_wr     <= 1'b0;
      r_mrd    <= 1'b0;
      r_mwr    <= 1'b0;
      r_maddr  <= '0;
      r_mdata  <= '0;
      r_z      <= 1'b0;
      r_halt   <= 1'b0;
      r_badop  <= 1'b0;
    end else if (!stall) begin
      r_ir     <= ir_in;
      r_pc     <= pc_in;
      r_result <= w_result;
      r_dest   <= w_insn.dest;
      r_wr     <= w_writes;
      r_mrd    <= w_is_mem && (w_insn.opcode == OPLDR);
      r_mwr    <= w_is_mem && (w_insn.opcode == OPSTR);
      r_maddr  <= w_is_mem ? op2_in : '0;
      r_mdata  <= (w_is_mem && (w_insn.opcode == OPSTR)) ? rd_val_in : '0;
      if (w_writes && (w_insn.cc == CC_S)) r_z <= (w_result == '0);
      if (w_insn.opcode == OPSYS)          r_halt  <= 1'b1;
      if (w_is_bad)                        r_badop <= 1'b1;
    end
  end

  assign ir_out       = r_ir;
  assign pc_out       = r_pc;
  assign result_out   = r_result;
  assign dest_out     = r_dest;
  assign wr_en_out    = r_wr;
  assign mem_rd_out   = r_mrd;
  assign mem_wr_out   = r_mwr;
  assign mem_addr_out = r_maddr;
  assign mem_data_out = r_mdata;
  assign z_out        = r_z;
  assign halt_out     = r_halt;
  assign badop_out    = r_badop;

endmodule

// File: tb/tb_stage2.sv
// Directed scoreboard bench for stage2: expected outputs queued at issue, checked after the edge.
module tb_stage2;
  import stage2_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [15:0] ir_in, pc_in, rd_val_in, op2_in;
  logic [15:0] ir_out, pc_out, result_out, mem_addr_out, mem_data_out;
  logic [3:0]  dest_out;
  logic        wr_en_out, mem_rd_out, mem_wr_out, z_out, halt_out, badop_out;

  typedef struct packed {
    logic [15:0] ir, pc, res;
    logic [3:0]  dest;
    logic        wr, mrd, mwr;
    logic [15:0] maddr, mdata;
    logic        z, halt, bad;
  } exp_t;

  exp_t m;
  exp_t rst_e;
  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  stage2 dut (
    .clk(clk), .reset(reset), .stall(stall),
    .ir_in(ir_in), .pc_in(pc_in), .rd_val_in(rd_val_in), .op2_in(op2_in),
    .ir_out(ir_out), .pc_out(pc_out), .result_out(result_out), .dest_out(dest_out),
    .wr_en_out(wr_en_out), .mem_rd_out(mem_rd_out), .mem_wr_out(mem_wr_out),
    .mem_addr_out(mem_addr_out), .mem_data_out(mem_data_out),
    .z_out(z_out), .halt_out(halt_out), .badop_out(badop_out)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mk(input logic [4:0] op, input logic [1:0] cc, input logic [3:0] d);
    return {op, cc, 1'b0, d, 4'h2};
  endfunction

  // Bit-serial reference for the signed shift.
  function automatic logic [15:0] sha_ref(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    int s;
    r = a;
    s = int'($signed(b));
    if (s > 0) for (int i = 0; i < s && i < 17; i++) r = {r[14:0], 1'b0};
    if (s < 0) for (int i = 0; i < -s && i < 17; i++) r = {r[15], r[15:1]};
    return r;
  endfunction

  function automatic exp_t model(input logic [15:0] ir, input logic [15:0] pc,
                                 input logic [15:0] a, input logic [15:0] b, input exp_t prev);
    exp_t e;
    logic [4:0]  op;
    logic [31:0] p;
    logic        alu;
    e = prev;
    op = ir[15:11];
    p = 32'(a) * 32'(b);
    alu = 1'b1;
    e.ir = ir; e.pc = pc; e.dest = ir[7:4];
    e.res = 16'h0; e.wr = 1'b0; e.mrd = 1'b0; e.mwr = 1'b0; e.maddr = 16'h0; e.mdata = 16'h0;
    case (op)
      5'd0:  e.res = a + b;
      5'd1:  e.res = a - b;
      5'd2:  e.res = a & b;
      5'd3:  e.res = a & ~b;
      5'd4:  e.res = a ^ b;
      5'd5:  e.res = a | b;
      5'd6:  e.res = b;
      5'd7:  e.res = 16'h0 - b;
      5'd8:  e.res = p[15:0];
      5'd9:  e.res = sha_ref(a, b);
      5'd10: e.res = ($signed(a) < $signed(b)) ? 16'h1 : 16'h0;
      default: alu = 1'b0;
    endcase
    if (alu) begin
      e.wr = 1'b1;
      if (ir[10:9] == 2'b01) e.z = (e.res == 16'h0);
    end
    if (op == 5'd11) begin e.mrd = 1'b1; e.maddr = b; end
    if (op == 5'd12) begin e.mwr = 1'b1; e.maddr = b; e.mdata = a; end
    if (op == 5'd13) e.halt = 1'b1;
    if (op >= 5'd14 && op <= 5'd23 && op != 5'd20) e.bad = 1'b1;
    return e;
  endfunction

  task automatic cmp(input string tag, input string f, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, f, obs, exp);
    end
  endtask

  task automatic chk(input string tag, input exp_t e);
    cmp(tag, "ir_out",       ir_out,               e.ir);
    cmp(tag, "pc_out",       pc_out,               e.pc);
    cmp(tag, "result_out",   result_out,           e.res);
    cmp(tag, "dest_out",     16'(dest_out),        16'(e.dest));
    cmp(tag, "wr_en_out",    16'(wr_en_out),       16'(e.wr));
    cmp(tag, "mem_rd_out",   16'(mem_rd_out),      16'(e.mrd));
    cmp(tag, "mem_wr_out",   16'(mem_wr_out),      16'(e.mwr));
    cmp(tag, "mem_addr_out", mem_addr_out,         e.maddr);
    cmp(tag, "mem_data_out", mem_data_out,         e.mdata);
    cmp(tag, "z_out",        16'(z_out),           16'(e.z));
    cmp(tag, "halt_out",     16'(halt_out),        16'(e.halt));
    cmp(tag, "badop_out",    16'(badop_out),       16'(e.bad));
  endtask

  // Drive one cycle of stimulus, queue the expected state, check after the edge.
  task automatic step(input string tag, input logic [15:0] ir, input logic [15:0] a,
                      input logic [15:0] b, input logic st);
    exp_t e;
    ir_in = ir; pc_in = pc_in + 16'h1; rd_val_in = a; op2_in = b; stall = st;
    if (!st) m = model(ir, pc_in, a, b, m);
    sb.push_back(m);
    @(posedge clk); #1;
    tests++;
    assert (sb.size() == 1) else begin
      fails++;
      $error("FAIL %s.queue observed=%0d expected=1", tag, sb.size());
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk(tag, e);
    end
  endtask

  initial begin
    rst_e = '{ir: 16'hA000, default: '0};
    reset = 1'b0; stall = 1'b1;
    ir_in = mk(OPADD, CC_S, 4'h1); pc_in = 16'h0100; rd_val_in = 16'h0; op2_in = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", rst_e);
    m = rst_e;
    stall = 1'b0;
    reset = 1'b1;

    step("add_zero",  mk(OPADD, CC_S,  4'h3), 16'h0005, 16'hFFFB, 1'b0);
    step("sha_right", mk(OPSHA, CC_AL, 4'h4), 16'h8000, 16'hFFFC, 1'b0);
    step("sha_left",  mk(OPSHA, CC_AL, 4'h5), 16'h0001, 16'h0003, 1'b0);
    step("sha_zero",  mk(OPSHA, CC_AL, 4'h5), 16'h1234, 16'h0000, 1'b0);
    step("sha_l16",   mk(OPSHA, CC_AL, 4'h5), 16'h1234, 16'h0010, 1'b0);
    step("sha_r16",   mk(OPSHA, CC_AL, 4'h5), 16'h8000, 16'hFFF0, 1'b0);
    step("sha_rmin",  mk(OPSHA, CC_AL, 4'h5), 16'h4000, 16'h8000, 1'b0);
    step("str",       mk(OPSTR, CC_AL, 4'h6), 16'h1234, 16'h0040, 1'b0);
    step("ldr",       mk(OPLDR, CC_AL, 4'h7), 16'h5555, 16'h0100, 1'b0);
    step("sub_nz",    mk(OPSUB, CC_S,  4'h8), 16'h0007, 16'h0002, 1'b0);
    step("orr_z",     mk(OPORR, CC_S,  4'h9), 16'h0000, 16'h0000, 1'b0);
    step("pre",       16'hC123,              16'h0000, 16'h0001, 1'b0);
    step("nop",       NOP_INSN,              16'h0000, 16'h0001, 1'b0);
    step("mul",       mk(OPMUL, CC_S,  4'hA), 16'h1234, 16'h0100, 1'b0);
    step("neg",       mk(OPNEG, CC_AL, 4'hB), 16'h0000, 16'h0001, 1'b0);
    step("slt_t",     mk(OPSLT, CC_AL, 4'hC), 16'hFFFF, 16'h0001, 1'b0);
    step("slt_f",     mk(OPSLT, CC_S,  4'hC), 16'h0001, 16'hFFFF, 1'b0);
    step("bic",       mk(OPBIC, CC_AL, 4'hD), 16'hF0F0, 16'h3030, 1'b0);
    step("eor",       mk(OPEOR, CC_AL, 4'hD), 16'hF0F0, 16'h3333, 1'b0);
    step("and",       mk(OPAND, CC_AL, 4'hD), 16'hF0F0, 16'h3333, 1'b0);
    step("mov",       mk(OPMOV, CC_S,  4'hE), 16'hAAAA, 16'h0077, 1'b0);
    step("mulf",      mk(OPMULF, CC_S, 4'h1), 16'h0003, 16'h0004, 1'b0);
    step("add_after", mk(OPADD, CC_AL, 4'h2), 16'h0003, 16'h0004, 1'b0);
    step("bad_22",    {5'd22, 11'h012},      16'h0001, 16'h0001, 1'b0);
    step("sub_hold",  mk(OPSUB, CC_S,  4'h3), 16'h0010, 16'h0010, 1'b0);
    step("stall1",    mk(OPSTR, CC_S,  4'h4), 16'h0999, 16'h0888, 1'b1);
    step("stall2",    mk(OPSYS, CC_S,  4'h4), 16'h0999, 16'h0888, 1'b1);
    step("stall3",    mk(OPMULF, CC_S, 4'h4), 16'h0999, 16'h0888, 1'b1);
    step("after_stl", mk(OPADD, CC_S,  4'h4), 16'h0001, 16'h0001, 1'b0);
    step("sys",       mk(OPSYS, CC_AL, 4'h0), 16'h0000, 16'h0000, 1'b0);
    step("halt_hold", NOP_INSN,              16'h0000, 16'h0000, 1'b0);

    // Asynchronous reset asserted while clk is high, away from any edge.
    stall = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("reset_async", rst_e);
    m = rst_e;
    reset = 1'b1;
    step("post_reset", mk(OPADD, CC_S, 4'h6), 16'h0002, 16'h0003, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stage2.md
STAGE2 -- requirements
Module: stage2

Interface
REQ-001 Clocking/reset: one clock; reset is asynchronous and active-low.
REQ-002 clk  in  1  rising-edge clock shared with stage0/stage1.
REQ-003 reset  in  1  asynchronous, active-low; 0 forces the reset state immediately.
REQ-004 stall  in  1  downstream hold; 1 freezes every stage2 register.
REQ-005 ir_in  in  16  instruction from stage1 (opcode [15:11], cc [10:9], imm [8], dest [7:4], op2 [3:0]).
REQ-006 pc_in  in  16  PC follow value from stage1.
REQ-007 rd_val_in  in  16  value of the register named by ir_in[7:4].
REQ-008 op2_in  in  16  resolved operand 2 (register, sign-extended immediate, or PRE-extended immediate).
REQ-009 ir_out, pc_out  out  16 each  registered copies of ir_in and pc_in.
REQ-010 result_out  out  16  registered ALU result.
REQ-011 dest_out  out  4  registered destination register number.
REQ-012 wr_en_out  out  1  register write request for dest_out.
REQ-013 mem_rd_out, mem_wr_out  out  1 each  load / store request.
REQ-014 mem_addr_out, mem_data_out  out  16 each  memory address / store data.
REQ-015 z_out  out  1  registered Z flag; feeds stage0 conditional squash.
REQ-016 halt_out  out  1  registered SYS indication.
REQ-017 badop_out  out  1  sticky unimplemented-opcode flag.

Function
REQ-018 Latency: one cycle; outputs reflect the instruction present on ir_in at the previous rising edge with stall=0.
REQ-019 Let a = rd_val_in, b = op2_in; all arithmetic is 16-bit, wraps modulo 2^16, no carry/overflow outputs.
REQ-020 ADD a+b; SUB a-b; AND a&b; BIC a&~b; EOR a^b; ORR a|b; MOV b; NEG 0-b; MUL low 16 bits of a*b (unsigned product).
REQ-021 SHA: b[15:0] as signed; b>0 shifts a left by b, b<0 shifts a arithmetic-right by -b; magnitude >=16 gives 0 (left) or 16{a[15]} (right); b=0 gives a.
REQ-022 SLT: result 1 when signed a < signed b, else 0.
REQ-023 All REQ-020..022 opcodes assert wr_en_out with dest_out = ir_in[7:4].
REQ-024 LDR: mem_rd_out=1, mem_addr_out=b, dest_out=ir_in[7:4], wr_en_out=0 (write-back owned by stage3).
REQ-025 STR: mem_wr_out=1, mem_addr_out=b, mem_data_out=a, wr_en_out=0.
REQ-026 NOP, PRE (ir_in[15:14]=11): no write, no memory request, Z unchanged.
REQ-027 SYS: halt_out=1 next cycle; no write; halt_out holds 1 until reset.
REQ-028 ADDF, SUBF, MULF, FTOI, ITOF, RECF and opcodes 10101-10111: treated as NOP and set badop_out, which stays 1 until reset.
REQ-029 Z flag: updated only when cc=S (01) and the opcode is a REQ-020..022 ALU op; z_out <= (result==0); all other instructions leave Z unchanged.
REQ-030 Stall: stall=1 at a rising edge holds every output register and Z; the instruction on ir_in is not consumed (stage1 holds it).
REQ-031 Memory and write strobes are single-cycle per instruction; a held stall repeats no side effects beyond holding levels.

Reset
REQ-032 reset=0 sets ir_out=16'hA000 (NOP), pc_out=0, result_out=0, dest_out=0, mem_addr_out=0, mem_data_out=0, and all 1-bit outputs including z_out and badop_out to 0.
REQ-033 Reset overrides stall; an instruction in flight at assertion is discarded with no write or memory request issued after release.
REQ-034 The first rising edge after reset deasserts captures ir_in normally.

Structure
REQ-035 Shared package holds WORD width, opcode constants (OPADD..OPPRE), CC codes (AL, S, NE, EQ) and the NOP encoding 16'hA000; stage0/stage1/stage2 all use it.
REQ-036 Combinational datapath is one sub-module, stage2_alu (inputs opcode, a, b; outputs result, writes, is_mem, is_bad); stage2 owns all registers.

Verification
REQ-037 ADD cc=S, a=16'h0005, b=16'hFFFB -> next cycle result_out=0, wr_en_out=1, z_out=1.
REQ-038 SHA a=16'h8000, b=16'hFFFC (-4) -> result_out=16'hF800; b=16'h0003 on a=16'h0001 -> 16'h0008; cc=AL so z_out unchanged.
REQ-039 STR a=16'h1234, b=16'h0040 -> mem_wr_out=1, mem_addr_out=16'h0040, mem_data_out=16'h1234, wr_en_out=0.
REQ-040 MULF then ADD -> badop_out=1 after MULF and remains 1; ADD still writes correct sum.
REQ-041 SUB issued, stall=1 for 3 cycles -> outputs hold SUB result for all 3; next instruction appears one cycle after stall=0.
REQ-042 SYS -> halt_out=1; assert reset mid-cycle -> all outputs return to REQ-032 values asynchronously.
